// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the location display slice.
package seg7_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_BLANK = 7'b1111111;
    localparam logic [6:0] DIG_0     = 7'b1000000;
    localparam logic [6:0] DIG_1     = 7'b1111001;
    localparam logic [6:0] DIG_2     = 7'b0100100;
    localparam logic [6:0] DIG_3     = 7'b0110000;
    localparam logic [6:0] DIG_4     = 7'b0011001;
    localparam logic [6:0] DIG_5     = 7'b0010010;
    localparam logic [6:0] DIG_6     = 7'b0000010;
    localparam logic [6:0] DIG_7     = 7'b1111000;
    localparam logic [6:0] DIG_8     = 7'b0000000;
    localparam logic [6:0] DIG_9     = 7'b0010000;

    // Single decimal digit to segments; anything above 9 shows blank
    function automatic logic [6:0] digit_seg(input logic [4:0] d);
        logic [6:0] seg;
        case (d)
            5'd0:    seg = DIG_0;
            5'd1:    seg = DIG_1;
            5'd2:    seg = DIG_2;
            5'd3:    seg = DIG_3;
            5'd4:    seg = DIG_4;
            5'd5:    seg = DIG_5;
            5'd6:    seg = DIG_6;
            5'd7:    seg = DIG_7;
            5'd8:    seg = DIG_8;
            5'd9:    seg = DIG_9;
            default: seg = HEX_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/all_seg7.sv
// Two-digit decimal decoder for a 0-31 location value onto HEX0/HEX1.
module all_seg7
    import seg7_pkg::*;
(
    input  logic [4:0] value,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    logic [4:0] tens;
    logic [4:0] ones;

    // Split into ones/tens, suppressing a leading zero on the tens digit
    always_comb begin
        tens = value / 5'd10;
        ones = value % 5'd10;
        HEX0 = digit_seg(ones);
        HEX1 = (tens == 5'd0) ? HEX_BLANK : digit_seg(tens);
        HEX2 = HEX_BLANK;
        HEX3 = HEX_BLANK;
        HEX4 = HEX_BLANK;
        HEX5 = HEX_BLANK;
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin owner of the shared location display, with minimum hold,
// optional blinking of the location digits and owner index on HEX5.
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0][4:0] req_loc,
    input  logic [NREQ-1:0]      req_blink,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3,
    output logic [6:0]           HEX4,
    output logic [6:0]           HEX5
);

    localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [4:0]         loc_q, loc_d;
    logic               blink_q, blink_d;

    logic [IDX_W:0]     pick_all;
    logic [IDX_W:0]     pick_oth;
    logic [NREQ-1:0]    owner_mask;
    logic               new_grant;
    logic [6:0]         dec_hex0;
    logic [6:0]         dec_hex1;
    logic [27:0]        unused_hex;

    // First set bit of mask scanning upward from from+1 (wrapping); returns {found, index}
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] mask,
                                               input logic [IDX_W-1:0] from);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((int'(from) + i) % NREQ);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign owner_mask = NREQ'(1) << last_q;

    // Arbitration, hold/blink counters, and capture of the owner's live value
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        new_grant   = 1'b0;
        pick_all    = rr_pick(req, last_q);
        pick_oth    = rr_pick(req & ~owner_mask, last_q);

        case (state_q)
            IDLE: begin
                hold_cnt_d  = '0;
                blink_cnt_d = '0;
                phase_d     = 1'b1;
                if (pick_all[IDX_W]) begin
                    state_d   = SHOW;
                    last_d    = pick_all[IDX_W-1:0];
                    new_grant = 1'b1;
                end
            end
            SHOW: begin
                if (!req[last_q]) begin
                    if (pick_oth[IDX_W]) begin
                        last_d    = pick_oth[IDX_W-1:0];
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if ((hold_cnt_q == HOLD_MAX) && pick_oth[IDX_W]) begin
                    last_d    = pick_oth[IDX_W-1:0];
                    new_grant = 1'b1;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end

                if (blink_q) begin
                    if (blink_cnt_q == BLINK_MAX) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end else begin
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
                end

                if (new_grant || (state_d == IDLE)) begin
                    hold_cnt_d  = '0;
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        loc_d   = req_loc[last_d];
        blink_d = req_blink[last_d];
    end

    // State and counters; reset leaves the pointer so requester 0 wins first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NREQ - 1);
            hold_cnt_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            loc_q       <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            loc_q       <= loc_d;
            blink_q     <= blink_d;
        end
    end

    all_seg7 u_dec (
        .value (loc_q),
        .HEX0  (dec_hex0),
        .HEX1  (dec_hex1),
        .HEX2  (unused_hex[6:0]),
        .HEX3  (unused_hex[13:7]),
        .HEX4  (unused_hex[20:14]),
        .HEX5  (unused_hex[27:21])
    );

    assign grant = (state_q == SHOW) ? owner_mask : '0;
    assign busy  = (state_q == SHOW);

    // Blanking mux: digits follow the blink phase, owner digit is steady
    always_comb begin
        HEX0 = HEX_BLANK;
        HEX1 = HEX_BLANK;
        HEX2 = HEX_BLANK;
        HEX3 = HEX_BLANK;
        HEX4 = HEX_BLANK;
        HEX5 = HEX_BLANK;
        if (state_q == SHOW) begin
            HEX5 = digit_seg(5'(last_q));
            if (phase_q) begin
                HEX0 = dec_hex0;
                HEX1 = dec_hex1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Self-checking bench for seg7_display_arbiter: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_seg7_display_arbiter;

    localparam int NREQ         = 2;
    localparam int HOLD_CYCLES  = 8;
    localparam int BLINK_CYCLES = 2;

    logic            clk;
    logic            reset_n;
    logic [1:0]      req;
    logic [1:0][4:0] req_loc;
    logic [1:0]      req_blink;
    logic [1:0]      grant;
    logic            busy;
    logic [6:0]      HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    // Model: owner (-1 idle), round-robin pointer, cycles since grant,
    // displayed value, displayed blink request, consecutive blinking cycles
    int m_owner, m_last, m_age, m_loc, m_run;
    bit m_blinkr;
    logic [6:0] e_grant, e_busy, e_h0, e_h1, e_h5;
    bit e_show, e_on;

    seg7_display_arbiter #(
        .NREQ         (NREQ),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .BLINK_CYCLES (BLINK_CYCLES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_loc   (req_loc),
        .req_blink (req_blink),
        .grant     (grant),
        .busy      (busy),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5)
    );

    // Free-running 100 MHz-style clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard seven-segment digit shapes, active low {g,f,e,d,c,b,a}
    function automatic logic [6:0] expSeg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int rrNext(input logic [1:0] r, input int from, input int excl);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (from + k) % NREQ;
            if (c != excl && r[c[0]]) return c;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [4:0] l0,
                                 input logic [4:0] l1, input logic [1:0] b);
        req        = r;
        req_loc[0] = l0;
        req_loc[1] = l1;
        req_blink  = b;
    endtask

    task automatic modelReset();
        m_owner  = -1;
        m_last   = NREQ - 1;
        m_age    = 0;
        m_run    = 0;
        m_loc    = 0;
        m_blinkr = 0;
    endtask

    task automatic modelGrant(input int who);
        m_owner = who;
        m_last  = who;
        m_age   = 0;
        m_run   = 0;
    endtask

    task automatic modelStep();
        int nxt;
        if (m_owner < 0) begin
            nxt = rrNext(req, m_last, -1);
            if (nxt >= 0) modelGrant(nxt);
        end else begin
            nxt = rrNext(req, m_last, m_owner);
            if (!req[m_owner[0]]) begin
                if (nxt >= 0) modelGrant(nxt);
                else begin
                    m_owner = -1;
                    m_age   = 0;
                    m_run   = 0;
                end
            end else if (m_age >= HOLD_CYCLES - 1 && nxt >= 0) begin
                modelGrant(nxt);
            end else begin
                m_age++;
                m_run = m_blinkr ? m_run + 1 : 0;
            end
        end
        if (m_owner >= 0) begin
            m_loc    = int'(req_loc[m_owner[0]]);
            m_blinkr = req_blink[m_owner[0]];
        end
    endtask

    // Model advances on every rising edge, held in reset while reset_n is low
    always @(posedge clk) begin
        if (!reset_n) modelReset();
        else modelStep();
    end

    // Asynchronous reset takes effect on the model immediately
    always @(negedge reset_n) modelReset();

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (check_en) begin
            e_show  = (m_owner >= 0);
            e_on    = e_show && (((m_run / BLINK_CYCLES) % 2) == 0);
            e_grant = e_show ? 7'(2'b01 << m_owner) : 7'd0;
            e_busy  = e_show ? 7'd1 : 7'd0;
            e_h0    = e_on ? expSeg(m_loc % 10) : 7'h7F;
            e_h1    = (e_on && m_loc >= 10) ? expSeg(m_loc / 10) : 7'h7F;
            e_h5    = e_show ? expSeg(m_owner) : 7'h7F;
            checkOutput("m_grant", 7'(grant), e_grant);
            checkOutput("m_busy", 7'(busy), e_busy);
            checkOutput("m_hex0", HEX0, e_h0);
            checkOutput("m_hex1", HEX1, e_h1);
            checkOutput("m_hex2", HEX2, 7'h7F);
            checkOutput("m_hex3", HEX3, 7'h7F);
            checkOutput("m_hex4", HEX4, 7'h7F);
            checkOutput("m_hex5", HEX5, e_h5);
        end
    end

    // Directed scenarios, then randomized traffic
    initial begin
        reset_n = 1'b0;
        applyStimulus(2'b00, 5'd0, 5'd0, 2'b00);
        repeat (3) @(negedge clk);
        checkOutput("rst_grant", 7'(grant), 7'd0);
        checkOutput("rst_busy", 7'(busy), 7'd0);
        checkOutput("rst_hex0", HEX0, 7'h7F);
        checkOutput("rst_hex5", HEX5, 7'h7F);
        reset_n  = 1'b1;
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_grant", 7'(grant), 7'd0);
        checkOutput("idle_hex1", HEX1, 7'h7F);

        // Both request at once: 0 first, rotate after 8 cycles, then back
        applyStimulus(2'b11, 5'd7, 5'd23, 2'b00);
        @(negedge clk);
        checkOutput("a_grant0", 7'(grant), 7'd1);
        checkOutput("a_hex0_7", HEX0, 7'b1111000);
        checkOutput("a_hex1_blank", HEX1, 7'h7F);
        checkOutput("a_hex5_0", HEX5, 7'b1000000);
        repeat (8) @(negedge clk);
        checkOutput("a_grant1", 7'(grant), 7'd2);
        checkOutput("a_hex0_3", HEX0, 7'b0110000);
        checkOutput("a_hex1_2", HEX1, 7'b0100100);
        checkOutput("a_hex5_1", HEX5, 7'b1111001);
        repeat (8) @(negedge clk);
        checkOutput("a_grant_back", 7'(grant), 7'd1);
        applyStimulus(2'b00, 5'd7, 5'd23, 2'b00);
        repeat (2) @(negedge clk);

        // Lone requester: live value tracking, no rotation, then late rival
        applyStimulus(2'b01, 5'd3, 5'd23, 2'b00);
        @(negedge clk);
        checkOutput("b_hex0_3", HEX0, 7'b0110000);
        repeat (2) @(negedge clk);
        applyStimulus(2'b01, 5'd31, 5'd23, 2'b00);
        @(negedge clk);
        checkOutput("b_hex0_1", HEX0, 7'b1111001);
        checkOutput("b_hex1_3", HEX1, 7'b0110000);
        repeat (10) @(negedge clk);
        checkOutput("b_keep", 7'(grant), 7'd1);
        applyStimulus(2'b11, 5'd31, 5'd23, 2'b00);
        @(negedge clk);
        checkOutput("b_rotate", 7'(grant), 7'd2);
        applyStimulus(2'b00, 5'd31, 5'd23, 2'b00);
        repeat (2) @(negedge clk);

        // Owner drops early: immediate handover with a fresh hold
        applyStimulus(2'b11, 5'd4, 5'd9, 2'b00);
        @(negedge clk);
        checkOutput("c_grant0", 7'(grant), 7'd1);
        repeat (2) @(negedge clk);
        applyStimulus(2'b10, 5'd4, 5'd9, 2'b00);
        @(negedge clk);
        checkOutput("c_handover", 7'(grant), 7'd2);
        checkOutput("c_hex0_9", HEX0, 7'b0010000);
        applyStimulus(2'b11, 5'd4, 5'd9, 2'b00);
        repeat (7) @(negedge clk);
        checkOutput("c_hold_fresh", 7'(grant), 7'd2);
        @(negedge clk);
        checkOutput("c_expire", 7'(grant), 7'd1);
        applyStimulus(2'b00, 5'd4, 5'd9, 2'b00);
        repeat (2) @(negedge clk);

        // Blinking "12": on, on, off, off, on; owner digit steady
        applyStimulus(2'b01, 5'd12, 5'd0, 2'b01);
        @(negedge clk);
        checkOutput("d_on0_hex0", HEX0, 7'b0100100);
        checkOutput("d_on0_hex1", HEX1, 7'b1111001);
        @(negedge clk);
        checkOutput("d_on1_hex0", HEX0, 7'b0100100);
        @(negedge clk);
        checkOutput("d_off0_hex0", HEX0, 7'h7F);
        checkOutput("d_off0_hex1", HEX1, 7'h7F);
        checkOutput("d_off0_hex5", HEX5, 7'b1000000);
        @(negedge clk);
        checkOutput("d_off1_hex0", HEX0, 7'h7F);
        @(negedge clk);
        checkOutput("d_on2_hex0", HEX0, 7'b0100100);

        // Asynchronous reset while requester 0 owns the display
        #2 reset_n = 1'b0;
        #1;
        checkOutput("e_grant", 7'(grant), 7'd0);
        checkOutput("e_busy", 7'(busy), 7'd0);
        checkOutput("e_hex0", HEX0, 7'h7F);
        checkOutput("e_hex5", HEX5, 7'h7F);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(2'b11, 5'd7, 5'd23, 2'b00);
        @(negedge clk);
        checkOutput("e_first_owner", 7'(grant), 7'd1);

        // Randomized traffic with occasional asynchronous reset pulses
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 5) == 0) req[1] = ~req[1];
            if ($urandom_range(0, 3) == 0) req_loc[0] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) req_loc[1] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) req_blink[0] = ~req_blink[0];
            if ($urandom_range(0, 7) == 0) req_blink[1] = ~req_blink[1];
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
